// File: rtl/multi_zone_light_ctrl_pkg.sv
// Shared types for the multi-zone lighting controller: per-zone state codes.
package light_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    STEADY    = 2'd2,
    RAMP_DOWN = 2'd3
  } zone_state_e;

endpackage

// File: rtl/multi_zone_light_ctrl_if.sv
// Front-end / lamp-driver bundle for the multi-zone lighting controller.
interface multi_zone_light_ctrl_if #(
  parameter int NUM_ZONES = 4,
  parameter int DUTY_W    = 8
);

  logic [NUM_ZONES-1:0]        app_switch;
  logic [NUM_ZONES-1:0]        movement;
  logic                        dark;
  logic [NUM_ZONES*DUTY_W-1:0] room_intensity;
  logic [NUM_ZONES-1:0]        light_control;
  logic [2*NUM_ZONES-1:0]      zone_state;

  modport master (
    output app_switch, movement, dark, room_intensity,
    input  light_control, zone_state
  );

  modport slave (
    input  app_switch, movement, dark, room_intensity,
    output light_control, zone_state
  );

endinterface

// File: rtl/multi_zone_light_ctrl_zone.sv
// One lighting zone: occupancy hold, target select, linear fade, state code, PWM compare.
// NIGHT_LIGHT_EN selects a NIGHT_LEVEL floor for unrequested zones while dark.
module light_zone
  import light_pkg::*;
#(
  parameter int DUTY_W      = 8,
  parameter int HOLD_CYCLES = 1000,
  parameter int NIGHT_LEVEL = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               app_i,
  input  logic               move_i,
  input  logic               dark_i,
  input  logic               fade_tick_i,
  input  logic [DUTY_W-1:0]  intensity_i,
  input  logic [DUTY_W-1:0]  pwm_cnt_i,
  output logic               light_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
`ifdef NIGHT_LIGHT_EN
  localparam logic FLOOR_EN = 1'b1;
`else
  localparam logic FLOOR_EN = 1'b0;
`endif
  localparam logic [DUTY_W-1:0] FLOOR_LVL = DUTY_W'(NIGHT_LEVEL);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DUTY_W-1:0]  level_q, level_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               light_q, light_d;
  logic               request;
  logic [DUTY_W-1:0]  target;

  // Motion only counts while dark; otherwise the hold just runs down.
  always_comb begin
    hold_d = hold_q;
    if (move_i && dark_i)
      hold_d = HOLD_LOAD;
    else if (hold_q != '0)
      hold_d = hold_q - 1'b1;
  end

  assign request = app_i | (hold_q != '0);

  always_comb begin
    target = '0;
    if (request)
      target = intensity_i;
    else if (FLOOR_EN && dark_i)
      target = FLOOR_LVL;
  end

  always_comb begin
    level_d = level_q;
    if (fade_tick_i) begin
      if (level_q < target)
        level_d = level_q + 1'b1;
      else if (level_q > target)
        level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    state_d = OFF;
    if (level_q < target)
      state_d = RAMP_UP;
    else if (level_q > target)
      state_d = RAMP_DOWN;
    else if (level_q != '0)
      state_d = STEADY;
  end

  assign light_d = (pwm_cnt_i < level_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      level_q <= '0;
      state_q <= OFF;
      light_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      level_q <= level_d;
      state_q <= state_d;
      light_q <= light_d;
    end
  end

  assign light_o = light_q;
  assign state_o = state_q;

endmodule

// File: rtl/multi_zone_light_ctrl.sv
// Multi-zone lighting controller top: input synchronisers, fade prescaler, shared PWM counter.
// Build with NIGHT_LIGHT_EN defined to give unrequested zones a night-light floor while dark.
module multi_zone_light_ctrl
  import light_pkg::*;
#(
  parameter int NUM_ZONES   = 4,
  parameter int DUTY_W      = 8,
  parameter int HOLD_CYCLES = 1000,
  parameter int FADE_DIV    = 16,
  parameter int NIGHT_LEVEL = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multi_zone_light_ctrl_if.slave  bus
);

  localparam int PRESC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(FADE_DIV - 1);

  logic [NUM_ZONES-1:0] app_s1_q, app_s2_q;
  logic [NUM_ZONES-1:0] move_s1_q, move_s2_q;
  logic                 dark_s1_q, dark_s2_q;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [DUTY_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic                 fade_tick;

  assign fade_tick = (presc_q == PRESC_LAST);
  assign presc_d   = fade_tick ? '0 : presc_q + 1'b1;
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_s1_q  <= '0;
      app_s2_q  <= '0;
      move_s1_q <= '0;
      move_s2_q <= '0;
      dark_s1_q <= 1'b0;
      dark_s2_q <= 1'b0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      app_s1_q  <= bus.app_switch;
      app_s2_q  <= app_s1_q;
      move_s1_q <= bus.movement;
      move_s2_q <= move_s1_q;
      dark_s1_q <= bus.dark;
      dark_s2_q <= dark_s1_q;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
    light_zone #(
      .DUTY_W      (DUTY_W),
      .HOLD_CYCLES (HOLD_CYCLES),
      .NIGHT_LEVEL (NIGHT_LEVEL)
    ) u_zone (
      .clk         (clk),
      .rst_n       (rst_n),
      .app_i       (app_s2_q[i]),
      .move_i      (move_s2_q[i]),
      .dark_i      (dark_s2_q),
      .fade_tick_i (fade_tick),
      .intensity_i (bus.room_intensity[i*DUTY_W +: DUTY_W]),
      .pwm_cnt_i   (pwm_cnt_q),
      .light_o     (bus.light_control[i]),
      .state_o     (bus.zone_state[STATE_W*i +: STATE_W])
    );
  end

endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// Directed bench for multi_zone_light_ctrl with 2 zones, 4-bit levels, hold 20, fade divider 2.
module tb_multi_zone_light_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  multi_zone_light_ctrl_if #(.NUM_ZONES(2), .DUTY_W(4)) bus ();

  multi_zone_light_ctrl #(
    .NUM_ZONES   (2),
    .DUTY_W      (4),
    .HOLD_CYCLES (20),
    .FADE_DIV    (2),
    .NIGHT_LEVEL (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; returns 1 ns after the last rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds reset for two edges with the given inputs applied, then releases it.
  task automatic apply_reset(input logic [1:0] app, input int i0, input int i1, input logic dk);
    rst_n                 = 1'b0;
    bus.app_switch        = app;
    bus.movement          = 2'b00;
    bus.dark              = dk;
    bus.room_intensity    = {4'(i1), 4'(i0)};
    step(2);
    check_eq("rst_light", int'(bus.light_control), 0);
    check_eq("rst_state", int'(bus.zone_state), 0);
    rst_n = 1'b1;
  endtask

  task automatic measure_duty(output int d0, output int d1);
    d0 = 0;
    d1 = 0;
    repeat (16) begin
      step(1);
      if (bus.light_control[0]) d0++;
      if (bus.light_control[1]) d1++;
    end
  endtask

  int d0, d1;

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Full-scale ramp on both zones straight out of reset.
    apply_reset(2'b11, 15, 15, 1'b0);
    check_eq("t1_state_early", int'(bus.zone_state), 0);
    step(32);
    check_eq("t1_ramp_last", int'(bus.zone_state), 4'b0101);
    step(1);
    check_eq("t1_steady", int'(bus.zone_state), 4'b1010);
    measure_duty(d0, d1);
    check_eq("t1_duty0", d0, 15);
    check_eq("t1_duty1", d1, 15);

    // Manual switch on zone 0 at half level, then off.
    apply_reset(2'b01, 8, 0, 1'b0);
    step(18);
    check_eq("t2_ramp_up", int'(bus.zone_state), 4'b0001);
    step(1);
    check_eq("t2_steady", int'(bus.zone_state), 4'b0010);
    measure_duty(d0, d1);
    check_eq("t2_duty0", d0, 8);
    check_eq("t2_duty1", d1, 0);
    bus.app_switch = 2'b00;
    step(17);
    check_eq("t2_ramp_down", int'(bus.zone_state), 4'b0011);
    step(1);
    check_eq("t2_off", int'(bus.zone_state), 0);

    // Zone 1 motion in the dark: auto-on for the hold time, then fade out.
    apply_reset(2'b00, 0, 10, 1'b0);
    step(2);
    bus.dark     = 1'b1;
    bus.movement = 2'b10;
    step(1);
    bus.movement = 2'b00;
    step(22);
    check_eq("t3_hold_steady", int'(bus.zone_state), 4'b1000);
    step(1);
    check_eq("t3_timeout_down", int'(bus.zone_state), 4'b1100);
    step(24);
    check_eq("t3_off", int'(bus.zone_state), 0);
    bus.dark = 1'b0;
    step(3);
    bus.movement = 2'b10;
    step(6);
    bus.movement = 2'b00;
    step(4);
    check_eq("t3_light_motion_state", int'(bus.zone_state), 0);
    measure_duty(d0, d1);
    check_eq("t3_light_motion_duty", d1, 0);

    // Retarget 12 -> 4 while zone 0 sits at level 6.
    apply_reset(2'b01, 12, 0, 1'b0);
    step(14);
    check_eq("t4_ramp_up", int'(bus.zone_state), 4'b0001);
    bus.room_intensity = {4'd0, 4'd4};
    step(1);
    check_eq("t4_retarget_down", int'(bus.zone_state), 4'b0011);
    step(3);
    check_eq("t4_still_down", int'(bus.zone_state), 4'b0011);
    step(1);
    check_eq("t4_steady", int'(bus.zone_state), 4'b0010);
    measure_duty(d0, d1);
    check_eq("t4_duty0", d0, 4);

    // Asynchronous reset while zone 0 is mid-fade at level 7 and lit.
    apply_reset(2'b01, 15, 0, 1'b0);
    step(17);
    check_eq("t5_lit_before", int'(bus.light_control), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_light", int'(bus.light_control), 0);
    check_eq("t5_async_state", int'(bus.zone_state), 0);
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check_eq("t5_release_light", int'(bus.light_control), 0);
    end

    // Dark with no request: night-light floor if built in, otherwise dark.
    apply_reset(2'b00, 9, 9, 1'b1);
    step(10);
    measure_duty(d0, d1);
`ifdef NIGHT_LIGHT_EN
    check_eq("t6_night_state", int'(bus.zone_state), 4'b1010);
    check_eq("t6_night_duty0", d0, 2);
    check_eq("t6_night_duty1", d1, 2);
`else
    check_eq("t6_dark_state", int'(bus.zone_state), 0);
    check_eq("t6_dark_duty0", d0, 0);
    check_eq("t6_dark_duty1", d1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
